// File: rtl/fifo_axis_reader_pkg.sv
// Shared defaults and width helpers for the FIFO-to-AXI4-Stream read adapter.
// Defaults describe a 960x540 frame of 24-bit pixels.
package fifo_axis_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32'd24;
    localparam int DEFAULT_LINE_PIXELS = 32'd960;
    localparam int DEFAULT_FRAME_LINES = 32'd540;

    // Counter width for a 0..n-1 range; a single bit is the floor.
    function automatic int cnt_width(input int n);
        return (n > 32'd2) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/fifo_axis_reader_stream_skid_buf.sv
// Two-entry output buffer (OUT plus SKID) with valid/ready on the output side.
// The producer guarantees it never writes while both entries are held and unpopped.
module stream_skid_buf
    import fifo_axis_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    logic                  out_valid_r;
    logic                  skid_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic                  pop_s;

    assign pop_s     = out_valid_r & out_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign occupancy = {1'b0, out_valid_r} + {1'b0, skid_valid_r};

    // OUT/SKID update: SKID drains into OUT first so beats leave in arrival order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            out_data_r   <= {DATA_WIDTH{1'b0}};
            skid_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (skid_valid_r) begin
            if (pop_s) begin
                out_data_r  <= skid_data_r;
                out_valid_r <= 1'b1;
                if (in_valid) begin
                    skid_data_r <= in_data;
                end else begin
                    skid_valid_r <= 1'b0;
                end
            end
        end else if (in_valid) begin
            if (!out_valid_r || pop_s) begin
                out_data_r  <= in_data;
                out_valid_r <= 1'b1;
            end else begin
                skid_data_r  <= in_data;
                skid_valid_r <= 1'b1;
            end
        end else if (pop_s) begin
            out_valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a 1-cycle-latency FIFO read port into an AXI4-Stream master with
// line (tlast) and frame (tuser) framing derived from beat counters.
module fifo_axis_reader
    import fifo_axis_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int LINE_PIXELS = DEFAULT_LINE_PIXELS,
    parameter int FRAME_LINES = DEFAULT_FRAME_LINES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_odata,
    input  logic                  fifo_empty,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done
);

    localparam int COL_W = cnt_width(LINE_PIXELS);
    localparam int ROW_W = cnt_width(FRAME_LINES);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_LINES - 1);

    logic             in_flight_r;
    logic             frame_done_r;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [1:0]       occ_s;
    logic [1:0]       level_s;
    logic             pop_s;
    logic             issue_s;
    logic             col_last_s;
    logic             row_last_s;

    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_flight_r),
        .in_data   (fifo_odata),
        .out_ready (m_axis_tready),
        .out_valid (m_axis_tvalid),
        .out_data  (m_axis_tdata),
        .occupancy (occ_s)
    );

    assign pop_s      = m_axis_tvalid & m_axis_tready;
    assign level_s    = occ_s + {1'b0, in_flight_r};
    assign col_last_s = (col_r == COL_LAST);
    assign row_last_s = (row_r == ROW_LAST);

    // Issue a read only when its data is guaranteed a free slot on landing.
    always_comb begin
        issue_s = 1'b0;
        if (rst_n && !fifo_empty) begin
            if (level_s < 2'd2) begin
                issue_s = 1'b1;
            end else if ((level_s == 2'd2) && pop_s) begin
                issue_s = 1'b1;
            end else begin
                issue_s = 1'b0;
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    assign fifo_rd       = issue_s;
    assign m_axis_tlast  = m_axis_tvalid & col_last_s;
    assign m_axis_tuser  = m_axis_tvalid & (col_r == {COL_W{1'b0}}) & (row_r == {ROW_W{1'b0}});
    assign frame_done    = frame_done_r;

    // In-flight tracking plus column/row counters that move only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_r  <= 1'b0;
            frame_done_r <= 1'b0;
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
        end else begin
            in_flight_r  <= issue_s;
            frame_done_r <= pop_s & col_last_s & row_last_s;
            if (pop_s) begin
                if (col_last_s) begin
                    col_r <= {COL_W{1'b0}};
                    row_r <= row_last_s ? {ROW_W{1'b0}} : (row_r + ROW_W'(1));
                end else begin
                    col_r <= col_r + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
Read-side adapter for the BRAM-based pixel FIFO in the axi-interface path. It drains the FIFO through its 1-cycle-latency read port (fifo_rd / fifo_odata / fifo_empty) and presents the pixels as an AXI4-Stream master with valid/ready backpressure. It supports full throughput: one beat per cycle when tready is held high. It also generates tuser (start of frame) and tlast (end of line) from line/frame counters for the upscaler datapath.

Parameters:
DATA_WIDTH, 24, pixel width in bits; must match the FIFO width.
LINE_PIXELS, 960, beats per line; tlast is asserted on the last beat of each line.
FRAME_LINES, 540, lines per frame; tuser is asserted on the first beat of each frame.

Ports:
clk  input  1  system clock; all state on the rising edge.
rst_n  input  1  asynchronous active-low reset, shared with the FIFO.
fifo_rd  output  1  FIFO pop request; fifo_odata is valid the cycle after fifo_rd.
fifo_odata  input  DATA_WIDTH  FIFO read data.
fifo_empty  input  1  FIFO empty flag.
m_axis_tvalid  output  1  stream beat valid.
m_axis_tready  input  1  downstream ready.
m_axis_tdata  output  DATA_WIDTH  pixel data.
m_axis_tlast  output  1  last beat of a line.
m_axis_tuser  output  1  first beat of a frame.
frame_done  output  1  one-cycle pulse after the last beat of a frame is accepted.

Behaviour:
- Reset: fifo_rd=0 while rst_n is low. All other outputs are 0. Buffer, in-flight flag and counters are cleared.
- Storage: 2 entries, an output register (OUT) plus a skid register (SKID). in_flight is a 1-bit flag set for the cycle following an issued read.
- level = valid(OUT) + valid(SKID) + in_flight. pop = m_axis_tvalid & m_axis_tready.
- Issue rule: fifo_rd = ~fifo_empty & ((level < 2) | (level == 2 & pop)). fifo_rd depends combinationally on tready; this is permitted.
- fifo_rd is never asserted when fifo_empty=1, because the in-flight accounting relies on every issued read returning data.
- Landing: in the cycle after an issue, fifo_odata is written to OUT if OUT is empty or is being popped (and SKID is empty), otherwise to SKID.
- On pop with SKID valid, SKID moves to OUT. Beat order is always FIFO order.
- Latency: first beat appears 1 cycle after the first fifo_rd, i.e. tvalid rises 2 edges after fifo_empty falls.
- AXI rules: once tvalid is high it stays high, with tdata/tlast/tuser stable, until accepted. Overflow is impossible by construction (level ≤ 2).
- Counters: col in 0..LINE_PIXELS-1 and row in 0..FRAME_LINES-1, both advance only on pop.
  - col wraps to 0 and row increments at col = LINE_PIXELS-1.
  - row wraps to 0 at the end of a frame.
- Sideband: m_axis_tlast = tvalid & (col == LINE_PIXELS-1). m_axis_tuser = tvalid & (col == 0) & (row == 0).
- frame_done is registered: high for exactly the cycle after the pop of the beat with col and row both at their maximum.
- FIFO empty mid-line: tvalid drops once the buffer drains. Counters hold, and the stream resumes at the same col/row.
- Simultaneous landing, pop and issue in one cycle is legal and sustains 1 beat/cycle.
- Reset mid-frame: any in-flight and buffered pixels are discarded and counters restart at 0. The FIFO pointers reset on the same rst_n, so no stale data is seen afterwards.
- Widths: COL_W = $clog2(LINE_PIXELS), ROW_W = $clog2(FRAME_LINES). LINE_PIXELS and FRAME_LINES must be ≥ 2.

Decomposition:
- Shared package/header: default DATA_WIDTH (24), default LINE_PIXELS/FRAME_LINES for the target resolution, COL_W/ROW_W derivation.
- Sub-module: stream_skid_buf. It holds the 2-entry OUT/SKID storage with valid/ready and exposes its occupancy. The issue logic, in_flight flag and counters stay in fifo_axis_reader.

Test Plan:
- Single pixel: write 0xA1B2C3 to the FIFO, tready=1 → fifo_rd asserted once; next cycle tvalid=1, tdata=0xA1B2C3, tuser=1; tvalid=0 afterwards.
- Streaming: 16 pixels preloaded, tready=1 → fifo_rd on 16 consecutive cycles, 16 consecutive beats, data 0..15 in order, no bubbles.
- Backpressure: streaming, then tready=0 for 3 cycles → at most 2 reads outstanding, fifo_rd=0 while level=2, tdata stable; resumes with no loss or duplication.
- Starvation: FIFO empties after pixel 5 and refills 4 cycles later → tvalid gap, pixel 6 follows with correct col.
- Framing (LINE_PIXELS=4, FRAME_LINES=2): 10 beats → tuser on beats 0 and 8; tlast on beats 3 and 7; frame_done one cycle after beat 7.
- Reset mid-frame at beat 5 with 1 read in flight → all outputs 0 during reset; after release, the next beat carries tuser=1.
